// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB3 master port among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait states.
module apb_rr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDRESS_WIDTH-1:0]         PADDR,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_RESET = PTR_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                     state;
  state_t                     next_state;
  logic [PTR_WIDTH-1:0]       ptr;
  logic [PTR_WIDTH-1:0]       grant;
  logic                       grant_found;
  logic [ADDRESS_WIDTH-1:0]   sel_addr;
  logic                       sel_write;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [STRB_WIDTH-1:0]      sel_strb;
  logic                       done;
  logic                       timeout;

  // Search above the pointer first, then wrap to the low requesters.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant       = ptr;
    grant_found = 1'b0;
    sel_addr    = '0;
    sel_write   = 1'b0;
    sel_wdata   = '0;
    sel_strb    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j] && (j > int'(ptr))) begin
        grant       = PTR_WIDTH'(j);
        grant_found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j] && (j <= int'(ptr))) begin
        grant       = PTR_WIDTH'(j);
        grant_found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (int'(grant) == j) begin
        sel_addr  = req_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write = req_write[j];
        sel_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[j*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  assign req_ready = (state == IDLE && grant_found) ? (NUM_REQ'(1) << grant) : '0;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wait_cnt;

  // Cleared during SETUP so every ACCESS phase starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

  // The cycle that would bring the count to the limit ends the transfer; PREADY still wins.
  assign timeout = (state == ACCESS) && !PREADY &&
                   (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout build the ACCESS phase waits for PREADY indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    next_state = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (grant_found) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS: begin
        if (PREADY || timeout) begin
          next_state = IDLE;
          done       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= PTR_RESET;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            ptr    <= grant;
            PADDR  <= sel_addr;
            PWRITE <= sel_write;
            PWDATA <= sel_wdata;
            PSTRB  <= sel_write ? sel_strb : '0;
            PSEL   <= 1'b1;
          end
        end
        SETUP: PENABLE <= 1'b1;
        ACCESS: begin
          // ptr still names the granted requester for the whole transfer.
          if (done) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << ptr;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/APB reference model.
module tb_apb_rr_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_write;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_strb;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    PADDR;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [SW-1:0]    PSTRB;
  logic [DW-1:0]    PRDATA;
  logic             PREADY;
  logic             PSLVERR;

  logic [AW-1:0] r_addr  [NR];
  logic [DW-1:0] r_wdata [NR];
  logic [SW-1:0] r_strb  [NR];

  int vectors     = 0;
  int miscompares = 0;
  int last_grant;

  apb_rr_arbiter #(
    .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
      req_strb[i*SW +: SW]  = r_strb[i];
    end
  end

  // Reference: first valid requester after the last one granted, wrapping modulo NR.
  function automatic int model_grant(input logic [NR-1:0] mask);
    logic [NR-1:0] sh;
    int c;
    for (int k = 1; k <= NR; k++) begin
      c  = (last_grant + k) % NR;
      sh = mask >> c;
      if (sh[0]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    r_addr[i]    = a;
    req_write[i] = w;
    r_wdata[i]   = d;
    r_strb[i]    = s;
  endtask

  task automatic scramble_requests();
    for (int i = 0; i < NR; i++) begin
      r_addr[i]  = AW'($urandom);
      r_wdata[i] = DW'($urandom);
      r_strb[i]  = SW'($urandom);
    end
    req_write = NR'($urandom);
    req_valid = NR'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      vectors++;
      if ({req_ready, rsp_valid, PSEL, PENABLE} !== '0) begin
        miscompares++;
        $display("FAIL idle: ready=%b rsp_valid=%b psel=%b penable=%b, expected all 0",
                 req_ready, rsp_valid, PSEL, PENABLE);
      end
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the completion negedge.
  task automatic run_txn(input logic [NR-1:0] mask, input int waits, input bit exp_timeout,
                         input logic err_in, input logic [DW-1:0] rdata_in);
    int g, n_access;
    logic [NR-1:0] e_oh;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [SW-1:0] e_strb;
    logic          e_err;
    req_valid = mask;
    #1;
    g    = model_grant(mask);
    e_oh = NR'(1) << g;
    vectors++;
    if (req_ready !== e_oh) begin
      miscompares++;
      $display("FAIL grant: req_ready=%b expected %b (mask %b)", req_ready, e_oh, mask);
    end
    e_addr     = r_addr[g];
    e_write    = req_write[g];
    e_wdata    = r_wdata[g];
    e_strb     = e_write ? r_strb[g] : '0;
    last_grant = g;

    @(negedge clk);
    scramble_requests();
    #1;
    vectors++;
    if ({PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PSTRB} !==
        {2'b10, {NR{1'b0}}, {NR{1'b0}}, e_addr, e_write, e_wdata, e_strb}) begin
      miscompares++;
      $display("FAIL setup: psel=%b pen=%b rdy=%b rv=%b addr=%h w=%b wd=%h st=%h, expected 1 0 0 0 %h %b %h %h",
               PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PSTRB,
               e_addr, e_write, e_wdata, e_strb);
    end

    n_access = exp_timeout ? TO : waits + 1;
    for (int w = 0; w < n_access; w++) begin
      @(negedge clk);
      scramble_requests();
      PREADY  = !exp_timeout && (w == waits);
      PSLVERR = PREADY ? err_in : 1'($urandom);
      PRDATA  = PREADY ? rdata_in : DW'($urandom);
      #1;
      vectors++;
      if ({PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PSTRB} !==
          {2'b11, {NR{1'b0}}, {NR{1'b0}}, e_addr, e_write, e_wdata, e_strb}) begin
        miscompares++;
        $display("FAIL access[%0d]: psel=%b pen=%b rdy=%b rv=%b addr=%h w=%b wd=%h st=%h, expected 1 1 0 0 %h %b %h %h",
                 w, PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PSTRB,
                 e_addr, e_write, e_wdata, e_strb);
      end
    end

    @(negedge clk);
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = DW'($urandom);
    req_valid = '0;
    e_rdata   = (exp_timeout || e_write) ? '0 : rdata_in;
    e_err     = exp_timeout ? 1'b1 : err_in;
    #1;
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE} !== {e_oh, e_rdata, e_err, 2'b00}) begin
      miscompares++;
      $display("FAIL response: rsp_valid=%b rdata=%h err=%b psel=%b pen=%b, expected %b %h %b 0 0",
               rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, e_oh, e_rdata, e_err);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_write = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    for (int i = 0; i < NR; i++) set_req(i, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: rv=%b rd=%h err=%b addr=%h psel=%b pen=%b pw=%b wd=%h st=%h, expected all 0",
               rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB);
    end
    @(negedge clk);
    rst        = 1'b1;
    last_grant = NR - 1;
    idle_cycles(2);
  endtask

  task automatic test_single_read();
    set_req(0, 32'h10, 1'b0, 32'h0, 4'hF);
    run_txn(3'b001, 0, 1'b0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_write_wait();
    set_req(1, 32'h20, 1'b1, 32'h12345678, 4'hF);
    run_txn(3'b010, 3, 1'b0, 1'b0, 32'hCAFEF00D);
  endtask

  task automatic test_round_robin();
    for (int t = 0; t < 4; t++) begin
      set_req(0, 32'h100 + t, 1'b0, 32'h0, 4'h0);
      set_req(1, 32'h200 + t, 1'b1, DW'($urandom), 4'h5);
      run_txn(3'b011, t % 2, 1'b0, 1'b0, DW'($urandom));
    end
  endtask

  task automatic test_err_strobe();
    idle_cycles(1);
    set_req(2, 32'h3C, 1'b0, 32'hFFFF_FFFF, 4'hF);
    run_txn(3'b100, 1, 1'b0, 1'b1, 32'h55AA55AA);
  endtask

  task automatic test_reset_in_access();
    idle_cycles(1);
    set_req(1, 32'h44, 1'b1, 32'hA5A5A5A5, 4'h3);
    @(negedge clk);
    req_valid = 3'b010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    PREADY = 1'b0;
    #1;
    vectors++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_access: psel=%b pen=%b, expected 1 1", PSEL, PENABLE);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({PSEL, PENABLE, rsp_valid} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: psel=%b pen=%b rv=%b, expected 0 0 0", PSEL, PENABLE, rsp_valid);
    end
    PREADY = 1'b1;
    repeat (2) @(negedge clk);
    PREADY = 1'b0;
    rst    = 1'b1;
    last_grant = NR - 1;
    idle_cycles(2);
  endtask

  task automatic test_fairness();
    for (int t = 0; t < 2 * NR; t++) begin
      for (int i = 0; i < NR; i++) set_req(i, AW'($urandom), 1'($urandom), DW'($urandom), SW'($urandom));
      run_txn({NR{1'b1}}, 0, 1'b0, 1'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] m;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NR; i++) set_req(i, AW'($urandom), 1'($urandom), DW'($urandom), SW'($urandom));
      m = NR'($urandom);
      if (m == '0) idle_cycles(1);
      else run_txn(m, int'($urandom_range(0, 3)), 1'b0, 1'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    set_req(0, 32'h80, 1'b0, 32'h0, 4'h0);
    run_txn(3'b001, 0, 1'b1, 1'b0, 32'h0);
    set_req(1, 32'h84, 1'b0, 32'h0, 4'h0);
    run_txn(3'b010, 0, 1'b0, 1'b0, 32'h0BADCAFE);
  endtask
`else
  task automatic test_long_wait();
    set_req(0, 32'h80, 1'b0, 32'h0, 4'h0);
    run_txn(3'b001, 20, 1'b0, 1'b0, 32'h0BADCAFE);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_err_strobe();
    test_reset_in_access();
    test_fairness();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB3 master port between NUM_REQ requesters using round-robin arbitration.
- Sequences each granted request through the APB SETUP and ACCESS phases and waits on PREADY.
- Returns read data and error status to the requester that was granted.
- Sits between the AXI-side bridge logic and the APB master modport that drives the peripheral bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDRESS_WIDTH, 32, PADDR and request address width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; the only clock in the block.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed request addresses.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_WIDTH  read data; shared bus, qualified by rsp_valid.
- rsp_err  out  1  completion error; qualified by rsp_valid.
- PADDR  out  ADDRESS_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB write strobe.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-low.
- Reset values: all outputs are 0; state = IDLE; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Output timing: all APB outputs, rsp_valid, rsp_rdata and rsp_err are registered. req_ready is combinational from state and req_valid.
- State machine: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE, any req_valid high:
  - Grant g = first requester with req_valid set, searching from pointer+1 upward and wrapping modulo NUM_REQ.
  - req_ready[g] = 1 for this cycle only.
  - Latch addr, write, wdata and strb of g; pointer <= g; next state SETUP.
  - If no req_valid is high, stay in IDLE with no req_ready.
- SETUP: PSEL=1, PENABLE=0; next state ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. Stay in ACCESS while PREADY=0.
- ACCESS, PREADY=1:
  - Next cycle: rsp_valid[g]=1, rsp_rdata = PRDATA if read else 0, rsp_err = PSLVERR.
  - PSEL and PENABLE = 0; state returns to IDLE.
- Address/control hold: PADDR, PWRITE, PWDATA and PSTRB hold the latched values from SETUP through the last ACCESS cycle. They keep their last value while idle.
- Read strobes: PSTRB is forced to 0 on reads.
- PENABLE is never high without PSEL. PSEL never drops mid-transfer except on reset or timeout.
- Latency: accept at cycle N, SETUP at N+1, ACCESS at N+2. Zero-wait completion gives rsp_valid at N+3. The next grant is possible at N+3, so back-to-back throughput is one transfer per 3 cycles plus wait states.
- Fairness: with all requesters continuously valid, grant order is 0,1,..,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 transfers.
- req_valid drop before grant: the request is simply not considered; no state is kept.
- Request after grant: requester inputs are ignored after the grant cycle.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The in-flight response is discarded and no rsp_valid is issued.
- Single-requester design: NUM_REQ=1 degenerates to a plain sequencer; the pointer is constant.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer terminates.
  - On termination: PSEL and PENABLE go to 0 next cycle; rsp_valid[g]=1, rsp_err=1, rsp_rdata=0; state returns to IDLE.
  - A PREADY arriving in the same cycle as the limit wins, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Single read: req0 read addr 0x10, PREADY=1 on the first ACCESS cycle, PRDATA=0xDEADBEEF -> PSEL at +1, PENABLE at +2; rsp_valid[0] at +3 with rdata 0xDEADBEEF, err=0.
- Write with wait states: req1 write 0x20/0x12345678, strb 0xF, PREADY held low 3 cycles -> PADDR/PWDATA/PSTRB stable for all 4 ACCESS cycles; rsp_valid[1], err=0, rdata=0.
- Round-robin: req0 and req1 both held valid for 4 transfers -> grant order 0,1,0,1; no cycle with two req_ready bits set.
- Error and read strobe: PSLVERR=1 with PREADY on a read that was issued with strb 0xF -> rsp_err=1; PSTRB=0 during the transfer.
- Reset in ACCESS: assert rst low while PENABLE=1 -> PSEL/PENABLE=0 immediately, no rsp_valid; after release, req0 is granted first.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY tied low -> after 4 ACCESS cycles, rsp_err=1, rdata=0, PSEL drops; the next request is served normally.
